// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a 64-bit word-addressed data memory.
// Sub-dword stores are read-modify-write; loads return a sign- or zero-extended lane.
module load_store_unit #(
    parameter int ADDR_W    = 64,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    localparam logic [ADDR_W-4:0] WORD_LIMIT = (ADDR_W-3)'(MEM_WORDS);

    state_t            state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       word_q;
    logic              misaligned;
    logic              out_of_range;

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Aligned accesses make the byte offset equal to the lane position for every size.
    function automatic logic [63:0] merge_lane(input logic [63:0] word, input logic [63:0] data,
                                               input logic [1:0] size, input logic [2:0] off);
        logic [5:0] sh;
        sh = {off, 3'b000};
        merge_lane = (word & ~(lane_mask(size) << sh)) | ((data & lane_mask(size)) << sh);
    endfunction

    function automatic logic [63:0] extract_lane(input logic [63:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [2:0] off);
        logic [5:0]  sh;
        logic [63:0] raw;
        logic        sign;
        sh  = {off, 3'b000};
        raw = (word >> sh) & lane_mask(size);
        case (size)
            2'b00:   sign = raw[7];
            2'b01:   sign = raw[15];
            2'b10:   sign = raw[31];
            default: sign = 1'b0;
        endcase
        extract_lane = (uns || !sign) ? raw : (raw | ~lane_mask(size));
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Full-width word index compare so high address bits can never alias into range.
    assign out_of_range = (req_addr[ADDR_W-1:3] >= WORD_LIMIT);
    assign req_ready    = (state == IDLE);
    assign resp_rdata   = (state == RSP && !we_q && !resp_err)
                        ? extract_lane(word_q, size_q, unsigned_q, addr_q[2:0]) : 64'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 64'h0;
            word_q     <= 64'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 64'h0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 64'h0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        if (misaligned || out_of_range) begin
                            state      <= RSP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && req_size == 2'b11) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
                        end
                    end
                end
                RD: begin
                    word_q <= mem_rdata;
                    if (we_q) begin
                        state     <= WR;
                        mem_write <= 1'b1;
                        mem_addr  <= {addr_q[ADDR_W-1:3], 3'b000};
                        mem_wdata <= merge_lane(mem_rdata, wdata_q, size_q, addr_q[2:0]);
                    end else begin
                        state      <= RSP;
                        resp_valid <= 1'b1;
                    end
                end
                WR: begin
                    state      <= RSP;
                    resp_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-level memory model plus a per-cycle compare process.
module tb_load_store_unit;

    localparam int ADDR_W    = 64;
    localparam int MEM_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid, resp_err, mem_read, mem_write;
    logic [63:0]       resp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    load_store_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational read, write on rising edge.
    logic [63:0] dmem [0:MEM_WORDS-1] = '{default: 64'h0};
    assign mem_rdata = dmem[mem_addr[10:3]];
    always @(posedge clk) if (mem_write) dmem[mem_addr[10:3]] <= mem_wdata;

    // Reference memory as individual bytes, updated when a store completes.
    logic [7:0] ref_mem [0:MEM_WORDS*8-1];

    int          tests_run = 0, tests_failed = 0;
    int          start_seq = 0, done_seq = 0;
    int          cyc = 0, rd_cnt = 0, wr_cnt = 0;
    logic [63:0] exp_rdata, exp_wdata, exp_mem_addr, lit_val;
    logic        exp_err, has_lit;
    int          exp_lat, exp_reads, exp_writes;
    string       cur_name;

    function automatic logic [63:0] modelLoad(input logic [63:0] a, input logic [1:0] sz, input logic uns);
        int          n, base;
        logic [63:0] v;
        n    = 1 << sz;
        base = int'(a[10:0]);
        v    = 64'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
        if (!uns && sz != 2'b11 && v[8*n-1])
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s (%s): got %h, expected %h", name, cur_name, act, req);
        end
    endtask

    // Compare process: checks every cycle against the expectations of the open transaction.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_state",
                {59'h0, req_ready, resp_valid, resp_err, mem_read, mem_write}
                | resp_rdata | mem_addr | mem_wdata, 64'h10);
            done_seq = start_seq;
            cyc = 0; rd_cnt = 0; wr_cnt = 0;
        end else begin
            checkOutput("rd_wr_exclusive", 64'(mem_read & mem_write), 64'h0);
            if (start_seq != done_seq) begin
                cyc++;
                if (mem_read)  rd_cnt++;
                if (mem_write) wr_cnt++;
                if (mem_read || mem_write) checkOutput("mem_addr", mem_addr, exp_mem_addr);
                if (mem_write) checkOutput("mem_wdata", mem_wdata, exp_wdata);
                if (resp_valid) begin
                    checkOutput("resp_rdata", resp_rdata, exp_rdata);
                    checkOutput("resp_err", 64'(resp_err), 64'(exp_err));
                    checkOutput("latency", 64'(cyc), 64'(exp_lat));
                    checkOutput("mem_read_count", 64'(rd_cnt), 64'(exp_reads));
                    checkOutput("mem_write_count", 64'(wr_cnt), 64'(exp_writes));
                    if (has_lit) checkOutput("literal_rdata", resp_rdata, lit_val);
                    done_seq = start_seq;
                    cyc = 0; rd_cnt = 0; wr_cnt = 0;
                end else if (cyc > 8) begin
                    checkOutput("resp_timeout", 64'(cyc), 64'(exp_lat));
                    done_seq = start_seq;
                    cyc = 0; rd_cnt = 0; wr_cnt = 0;
                end
            end else begin
                checkOutput("idle_quiet", {61'h0, resp_valid, mem_read, mem_write}, 64'h0);
                checkOutput("idle_bus", mem_addr | mem_wdata, 64'h0);
            end
        end
    end

    task automatic setExpect(input string name, input logic we, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic lit_en, input logic [63:0] lit);
        int          n, wbase, off;
        logic        err;
        logic [63:0] old_word;
        n     = 1 << size;
        err   = ((addr % 64'(n)) != 0) || ((addr >> 3) >= 64'(MEM_WORDS));
        wbase = int'({addr[10:3], 3'b000});
        off   = int'(addr[2:0]);
        old_word = 64'h0;
        for (int i = 0; i < 8; i++) old_word[8*i +: 8] = ref_mem[wbase + i];
        exp_wdata = old_word;
        for (int i = 0; i < n; i++) exp_wdata[8*(off+i) +: 8] = wdata[8*i +: 8];
        cur_name     = name;
        exp_err      = err;
        exp_rdata    = (err || we) ? 64'h0 : modelLoad(addr, size, uns);
        exp_lat      = err ? 1 : (!we ? 2 : (size == 2'b11 ? 2 : 3));
        exp_reads    = (err || (we && size == 2'b11)) ? 0 : 1;
        exp_writes   = (!err && we) ? 1 : 0;
        exp_mem_addr = {addr[63:3], 3'b000};
        has_lit      = lit_en;
        lit_val      = lit;
    endtask

    task automatic driveAccept(input logic we, input logic [1:0] size, input logic uns,
                               input logic [63:0] addr, input logic [63:0] wdata);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        start_seq++;
    endtask

    task automatic applyStimulus(input string name, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic lit_en, input logic [63:0] lit);
        int guard;
        setExpect(name, we, size, uns, addr, wdata, lit_en, lit);
        driveAccept(we, size, uns, addr, wdata);
        guard = 0;
        while (done_seq != start_seq && guard < 40) begin
            @(negedge clk); #1;
            guard++;
        end
        if (we && !exp_err)
            for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr[10:0]) + i] = wdata[8*i +: 8];
    endtask

    // Byte store whose WR cycle is cut short by reset; the model memory stays unchanged.
    task automatic abortedStore(input logic [63:0] addr, input logic [7:0] data);
        setExpect("aborted_store", 1'b1, 2'b00, 1'b0, addr, {56'h0, data}, 1'b0, 64'h0);
        driveAccept(1'b1, 2'b00, 1'b0, addr, {56'h0, data});
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS*8; i++) ref_mem[i] = 8'h00;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 64'h0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        applyStimulus("t1_st",  1, 2'b11, 0, 64'h0, 64'hA5A5A5A5A5A5A5A5, 0, 64'h0);
        applyStimulus("t1_ld",  0, 2'b11, 0, 64'h0, 64'h0, 1, 64'hA5A5A5A5A5A5A5A5);

        applyStimulus("t2_st",  1, 2'b11, 0, 64'h8, 64'h123456789ABCDEF0, 0, 64'h0);
        applyStimulus("t2_sb",  1, 2'b00, 0, 64'hB, 64'hFF, 0, 64'h0);
        applyStimulus("t2_ld",  0, 2'b11, 0, 64'h8, 64'h0, 1, 64'h12345678FFBCDEF0);

        applyStimulus("t3_lb",  0, 2'b00, 0, 64'hB, 64'h0, 1, 64'hFFFFFFFFFFFFFFFF);
        applyStimulus("t3_lbu", 0, 2'b00, 1, 64'hB, 64'h0, 1, 64'h00000000000000FF);
        applyStimulus("t3_lh",  0, 2'b01, 0, 64'hE, 64'h0, 1, 64'h0000000000001234);
        applyStimulus("t3_lwu", 0, 2'b10, 1, 64'hC, 64'h0, 1, 64'h0000000012345678);
        applyStimulus("t3_lw",  0, 2'b10, 0, 64'h8, 64'h0, 1, 64'hFFFFFFFFFFBCDEF0);

        applyStimulus("t4_st0", 1, 2'b11, 0, 64'h10, 64'h0, 0, 64'h0);
        applyStimulus("t4_lh9", 0, 2'b01, 0, 64'h9, 64'h0, 1, 64'h0);
        applyStimulus("t4_swA", 1, 2'b10, 0, 64'hA, 64'h1, 1, 64'h0);
        applyStimulus("t4_ld",  0, 2'b11, 0, 64'h10, 64'h0, 1, 64'h0);
        applyStimulus("t4_sh",  1, 2'b01, 0, 64'h12, 64'hBEEF, 0, 64'h0);
        applyStimulus("t4_lwu", 0, 2'b10, 1, 64'h10, 64'h0, 1, 64'h00000000BEEF0000);

        applyStimulus("t5_ldlast", 0, 2'b11, 0, 64'h7F8, 64'h0, 1, 64'h0);
        applyStimulus("t5_st800",  1, 2'b11, 0, 64'h800, 64'h5A5A5A5A5A5A5A5A, 1, 64'h0);
        applyStimulus("t5_ldhigh", 0, 2'b11, 0, 64'h8000000000000000, 64'h0, 1, 64'h0);
        applyStimulus("t5_stlast", 1, 2'b11, 0, 64'h7F8, 64'hCAFEF00DDEADBEEF, 0, 64'h0);
        applyStimulus("t5_ldlst2", 0, 2'b11, 0, 64'h7F8, 64'h0, 1, 64'hCAFEF00DDEADBEEF);

        applyStimulus("t6_st",  1, 2'b11, 0, 64'h10, 64'h0123456789ABCDEF, 0, 64'h0);
        abortedStore(64'h10, 8'hAB);
        applyStimulus("t6_ld",  0, 2'b11, 0, 64'h10, 64'h0, 1, 64'h0123456789ABCDEF);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
